srt_div_core: RTL and testbench

- 32-bit iterative integer divider with a ready/valid input and a valid-only output.
- Produces quotient and remainder for signed or unsigned operands.
- Sits inside the lane divide unit, which registers the request, feeds this block, and picks quotient or remainder for the lane response.
- Output has no backpressure; the consumer must take the result in the cycle output_valid is high.

---
 rtl/srt_div_core.sv | 80 ++++++++
 tb/tb_srt_div_core.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/srt_div_core.sv
// srt_div_core: 32-bit iterative radix-4 divider (signed/unsigned), fixed 18-cycle accept-to-result latency.
module srt_div_core (
  input  logic        clock,
  input  logic        reset,
  output logic        input_ready,
  input  logic        input_valid,
  input  logic [31:0] input_bits_dividend,
  input  logic [31:0] input_bits_divisor,
  input  logic        input_bits_signIn,
  output logic        output_valid,
  output logic [31:0] output_bits_reminder,
  output logic [31:0] output_bits_quotient
);
  typedef enum logic [2:0] {IDLE, PRE, ITER, POST, DONE} state_t;
  state_t state, stateNext;
  logic [31:0] dividendRaw, dividendShift, divisorAbs, quo, rem, remNext;
  logic [31:0] absA, absB, quotientReg, reminderReg;
  logic        negQ, negR, divZero, accept;
  logic [3:0]  count;
  logic [1:0]  digit;
  logic [33:0] shifted;
  logic [34:0] diff1, diff2, diff3;
  assign accept = input_valid & input_ready;
  assign input_ready = (state == IDLE) | (state == DONE);
  assign output_valid = state == DONE;
  assign output_bits_quotient = quotientReg;
  assign output_bits_reminder = reminderReg;
  assign absA = (input_bits_signIn & input_bits_dividend[31]) ? -input_bits_dividend : input_bits_dividend;
  assign absB = (input_bits_signIn & input_bits_divisor[31]) ? -input_bits_divisor : input_bits_divisor;
  // One radix-4 step: pick the largest digit in 0..3 that keeps the partial remainder non-negative.
  always_comb begin
    shifted = {rem, dividendShift[31:30]};
    diff1 = {1'b0, shifted} - {3'b0, divisorAbs};
    diff2 = {1'b0, shifted} - {2'b0, divisorAbs, 1'b0};
    diff3 = {1'b0, shifted} - ({2'b0, divisorAbs, 1'b0} + {3'b0, divisorAbs});
    digit = !diff3[34] ? 2'd3 : !diff2[34] ? 2'd2 : !diff1[34] ? 2'd1 : 2'd0;
    remNext = !diff3[34] ? diff3[31:0] : !diff2[34] ? diff2[31:0] : !diff1[34] ? diff1[31:0] : shifted[31:0];
  end
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    stateNext = accept ? PRE : IDLE;
      PRE:     stateNext = ITER;
      ITER:    stateNext = (count == 4'd14) ? POST : ITER;
      POST:    stateNext = DONE;
      default: stateNext = accept ? PRE : IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      quotientReg <= '0;
      reminderReg <= '0;
    end else begin
      state <= stateNext;
      if (accept) begin
        dividendRaw <= input_bits_dividend;
        dividendShift <= absA;
        divisorAbs <= absB;
        negQ <= input_bits_signIn & (input_bits_dividend[31] ^ input_bits_divisor[31]);
        negR <= input_bits_signIn & input_bits_dividend[31];
        divZero <= input_bits_divisor == '0;
        rem <= '0;
        quo <= '0;
        count <= '0;
      end
      // PRE issues the first of the 16 steps so the busy window stays at 17 cycles.
      if (state == PRE || state == ITER) begin
        rem <= remNext;
        quo <= {quo[29:0], digit};
        dividendShift <= {dividendShift[29:0], 2'b00};
        count <= (state == ITER) ? count + 4'd1 : count;
      end
      if (state == POST) begin
        quotientReg <= divZero ? '1 : negQ ? -quo : quo;
        reminderReg <= divZero ? dividendRaw : negR ? -rem : rem;
      end
    end
  end
endmodule

// File: tb/tb_srt_div_core.sv
// tb_srt_div_core: directed and reference-checked tests for srt_div_core.
module tb_srt_div_core;
  logic        clock = 0, reset = 1, input_valid = 0, input_bits_signIn = 0;
  logic [31:0] input_bits_dividend = 0, input_bits_divisor = 0;
  logic        input_ready, output_valid;
  logic [31:0] output_bits_reminder, output_bits_quotient;
  int vectors = 0, miscompares = 0;

  srt_div_core dut (
    .clock(clock), .reset(reset), .input_ready(input_ready), .input_valid(input_valid),
    .input_bits_dividend(input_bits_dividend), .input_bits_divisor(input_bits_divisor),
    .input_bits_signIn(input_bits_signIn), .output_valid(output_valid),
    .output_bits_reminder(output_bits_reminder), .output_bits_quotient(output_bits_quotient)
  );

  always #5 clock = ~clock;

  // Issue one op from idle; report result, latency (-1 on timeout), early-ready and pulse-width errors.
  task automatic runOp(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output logic [31:0] q, output logic [31:0] r, output int lat,
                       output bit readyBad, output bit pulseBad);
    @(negedge clock);
    input_bits_dividend = a; input_bits_divisor = b; input_bits_signIn = s; input_valid = 1;
    @(posedge clock);
    lat = -1; readyBad = 0; pulseBad = 0; q = 'x; r = 'x;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (k == 1) begin
        input_valid = 0; input_bits_dividend = $urandom; input_bits_divisor = $urandom; input_bits_signIn = ~s;
      end
      if (k < 18 && input_ready) readyBad = 1;
      if (output_valid) begin
        lat = k; q = output_bits_quotient; r = output_bits_reminder;
        break;
      end
    end
    @(negedge clock);
    if (output_valid) pulseBad = 1;
  endtask

  task automatic checkOp(input string name, input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [31:0] eq, input logic [31:0] er);
    logic [31:0] q, r; int lat; bit rb, pb;
    runOp(a, b, s, q, r, lat, rb, pb);
    vectors++;
    if (q !== eq) begin miscompares++; $display("FAIL %s quotient: got %h want %h", name, q, eq); end
    vectors++;
    if (r !== er) begin miscompares++; $display("FAIL %s remainder: got %h want %h", name, r, er); end
    vectors++;
    if (lat != 18 || rb || pb) begin
      miscompares++; $display("FAIL %s timing: latency %0d earlyReady %0d longPulse %0d want 18/0/0", name, lat, rb, pb);
    end
  endtask

  task automatic test_reset;
    int bad = 0;
    repeat (3) @(posedge clock);
    @(negedge clock); reset = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (input_ready !== 1'b1 || output_valid !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin miscompares++; $display("FAIL reset_idle: %0d bad cycles want 0", bad); end
    vectors++;
    if (output_bits_quotient !== 0 || output_bits_reminder !== 0) begin
      miscompares++; $display("FAIL reset_outputs: q=%h r=%h want 0/0", output_bits_quotient, output_bits_reminder);
    end
    checkOp("u100div7", 100, 7, 0, 14, 2);
  endtask

  task automatic test_signed;
    checkOp("s_m7div2", 32'hFFFFFFF9, 2, 1, 32'hFFFFFFFD, 32'hFFFFFFFF);
    checkOp("s_7divm2", 7, 32'hFFFFFFFE, 1, 32'hFFFFFFFD, 1);
    checkOp("u_fff9div2", 32'hFFFFFFF9, 2, 0, 32'h7FFFFFFC, 1);
    checkOp("s_m7divm2", 32'hFFFFFFF9, 32'hFFFFFFFE, 1, 3, 32'hFFFFFFFF);
  endtask

  task automatic test_boundaries;
    checkOp("u_div0", 32'h12345678, 0, 0, 32'hFFFFFFFF, 32'h12345678);
    checkOp("s_div0", 32'h12345678, 0, 1, 32'hFFFFFFFF, 32'h12345678);
    checkOp("s_negdiv0", 32'h87654321, 0, 1, 32'hFFFFFFFF, 32'h87654321);
    checkOp("s_overflow", 32'h80000000, 32'hFFFFFFFF, 1, 32'h80000000, 0);
    checkOp("u_8000divffff", 32'h80000000, 32'hFFFFFFFF, 0, 0, 32'h80000000);
    checkOp("zero_dividend", 0, 5, 1, 0, 0);
    checkOp("zero_div_zero", 0, 0, 0, 32'hFFFFFFFF, 0);
    checkOp("u_max_div1", 32'hFFFFFFFF, 1, 0, 32'hFFFFFFFF, 0);
  endtask

  task automatic test_back_to_back;
    bit sawExtra = 0;
    @(negedge clock);
    input_bits_dividend = 10; input_bits_divisor = 3; input_bits_signIn = 0; input_valid = 1;
    @(posedge clock);
    for (int k = 1; k <= 37; k++) begin
      @(negedge clock);
      if (k == 1) begin input_bits_dividend = 32'hFFFFFFFF; input_bits_divisor = 32'h10; end
      if (k == 19) input_valid = 0;
      if (k == 18 || k == 36) begin
        vectors++;
        if (output_valid !== 1'b1 || input_ready !== 1'b1) begin
          miscompares++; $display("FAIL b2b_valid_%0d: valid %b ready %b want 1/1", k, output_valid, input_ready);
        end
        vectors++;
        if (k == 18 && (output_bits_quotient !== 3 || output_bits_reminder !== 1)) begin
          miscompares++; $display("FAIL b2b_first: q=%h r=%h want 3/1", output_bits_quotient, output_bits_reminder);
        end
        if (k == 36 && (output_bits_quotient !== 32'h0FFFFFFF || output_bits_reminder !== 32'hF)) begin
          miscompares++; $display("FAIL b2b_second: q=%h r=%h want 0fffffff/f", output_bits_quotient, output_bits_reminder);
        end
      end else if (output_valid) sawExtra = 1;
    end
    vectors++;
    if (sawExtra) begin miscompares++; $display("FAIL b2b_extra: valid seen outside T+18/T+36 got 1 want 0"); end
  endtask

  task automatic test_mid_reset;
    bit sawValid = 0;
    @(negedge clock);
    input_bits_dividend = 100; input_bits_divisor = 7; input_bits_signIn = 0; input_valid = 1;
    @(posedge clock);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clock);
      if (k == 1) input_valid = 0;
    end
    reset = 1;
    @(negedge clock);
    reset = 0;
    vectors++;
    if (input_ready !== 1'b1) begin miscompares++; $display("FAIL midreset_ready: got %b want 1", input_ready); end
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (output_valid) sawValid = 1;
    end
    vectors++;
    if (sawValid) begin miscompares++; $display("FAIL midreset_novalid: got valid want none"); end
    checkOp("after_reset_1000div10", 1000, 10, 0, 100, 0);
  endtask

  task automatic test_random;
    logic [31:0] a, b, eq, er, q, r; logic s; int lat; bit rb, pb; int bad = 0;
    for (int i = 0; i < 300; i++) begin
      a = $urandom; b = $urandom; s = $urandom_range(0, 1);
      case ($urandom_range(0, 5))
        0: b = $urandom_range(0, 20);
        1: b = -$urandom_range(1, 20);
        2: a = $urandom_range(0, 1000);
        3: b = b >> $urandom_range(0, 31);
        default: ;
      endcase
      if (b == 0) begin eq = '1; er = a; end
      else if (s && a == 32'h80000000 && b == 32'hFFFFFFFF) begin eq = 32'h80000000; er = 0; end
      else if (s) begin eq = $signed(a) / $signed(b); er = $signed(a) % $signed(b); end
      else begin eq = a / b; er = a % b; end
      runOp(a, b, s, q, r, lat, rb, pb);
      vectors++;
      if (q !== eq || r !== er || lat != 18 || rb || pb) begin
        miscompares++; bad++;
        if (bad < 10) $display("FAIL random %h/%h s=%b: q=%h r=%h lat=%0d want q=%h r=%h lat=18", a, b, s, q, r, lat, eq, er);
      end
    end
  endtask

  initial begin
    test_reset;
    test_signed;
    test_boundaries;
    test_back_to_back;
    test_mid_reset;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
